// File: rtl/wave_seq_ctrl_if.sv
// Control and data bundle between the playback sequencer, the wavetable ROM
// and the PDM modulator. The sequencer attaches through the slave modport.
interface wave_seq_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] tuning_word;
  logic [CNT_W-1:0]   num_periods;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_q;
  logic [DATA_W-1:0]  sample;
  logic               sample_valid;
  logic               pdm_rst;
  logic               period_wrap;
  logic               busy;
  logic               done;

  modport slave (
    input  start, stop, tuning_word, num_periods, rom_q,
    output rom_addr, sample, sample_valid, pdm_rst, period_wrap, busy, done
  );

  modport master (
    output start, stop, tuning_word, num_periods, rom_q,
    input  rom_addr, sample, sample_valid, pdm_rst, period_wrap, busy, done
  );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Wavetable playback sequencer: phase-accumulator addressing, start/stop and
// period-count control, and a latency-tracked valid tag so that every address
// issued to the ROM produces exactly one valid sample toward the PDM modulator.
module wave_seq_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16,
  parameter int ROM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  wave_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Drain counter only needs to hold ROM_LAT-1.
  localparam int DRAIN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

  state_t               state_reg;
  logic [PHASE_W-1:0]   phase_reg;
  logic [PHASE_W-1:0]   tw_reg;
  logic [CNT_W-1:0]     np_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [DRAIN_W-1:0]   drain_reg;
  logic [ROM_LAT-1:0]   pipe_reg;
  logic [DATA_W-1:0]    sample_reg;
  logic                 valid_reg;
  logic                 wrap_reg;
  logic                 busy_reg;
  logic                 pdm_rst_reg;
  logic                 done_reg;

  logic [PHASE_W:0]     phase_sum;
  logic                 carry;
  logic [CNT_W-1:0]     count_next;
  logic                 period_end;
  logic                 last_run;
  logic                 tag;
  logic                 pipe_tail;

  // Accumulator step with explicit carry-out; the carry marks a period boundary.
  assign phase_sum  = {1'b0, phase_reg} + {1'b0, tw_reg};
  assign carry      = phase_sum[PHASE_W];
  // The count is compared for equality only, so in continuous mode it may wrap freely.
  assign count_next = count_reg + CNT_W'(1);
  assign period_end = carry && (np_reg != '0) && (count_next == np_reg);
  assign last_run   = period_end || bus.stop;
  // Every RUN cycle issues exactly one address, so the tag is just "in RUN".
  assign tag        = (state_reg == RUN);
  assign pipe_tail  = pipe_reg[ROM_LAT-1];

  assign bus.rom_addr     = tag ? phase_reg[PHASE_W-1 -: ADDR_W] : '0;
  assign bus.sample       = sample_reg;
  assign bus.sample_valid = valid_reg;
  assign bus.period_wrap  = wrap_reg;
  assign bus.busy         = busy_reg;
  assign bus.pdm_rst      = pdm_rst_reg;
  assign bus.done         = done_reg;

  // Playback FSM with phase/count bookkeeping and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      tw_reg      <= '0;
      np_reg      <= '0;
      count_reg   <= '0;
      drain_reg   <= '0;
      wrap_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      pdm_rst_reg <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      wrap_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A zero tuning word would never advance, so such a start is ignored.
          if (bus.start && (bus.tuning_word != '0)) begin
            tw_reg      <= bus.tuning_word;
            np_reg      <= bus.num_periods;
            phase_reg   <= '0;
            count_reg   <= '0;
            state_reg   <= RUN;
            busy_reg    <= 1'b1;
            pdm_rst_reg <= 1'b0;
          end
        end
        RUN: begin
          phase_reg <= phase_sum[PHASE_W-1:0];
          if (carry) begin
            wrap_reg  <= 1'b1;
            count_reg <= count_next;
          end
          // The current address is still issued and tagged on the exit cycle.
          if (last_run) begin
            state_reg <= DRAIN;
            drain_reg <= DRAIN_W'(ROM_LAT - 1);
          end
        end
        DRAIN: begin
          if (drain_reg == '0) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            drain_reg <= drain_reg - DRAIN_W'(1);
          end
        end
        DONE: begin
          state_reg   <= IDLE;
          busy_reg    <= 1'b0;
          pdm_rst_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Valid-tag pipe matched to ROM latency, and the output sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg   <= '0;
      sample_reg <= MID_SCALE;
      valid_reg  <= 1'b0;
    end else begin
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
      pipe_reg[0] <= tag;
      valid_reg   <= pipe_tail;
      // Leaving DONE returns the modulator input to mid-scale for IDLE.
      if (state_reg == DONE) begin
        sample_reg <= MID_SCALE;
      end else if (pipe_tail) begin
        sample_reg <= bus.rom_q;
      end
    end
  end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: behavioural ROM, arithmetic playback
// model checked every cycle, directed scenarios and randomized control traffic.
module tb_wave_seq_ctrl;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int PHASE_W = 16;
  localparam int ROM_LAT = 2;
  localparam int CNT_W   = 16;
  localparam longint INF = 64'd1 << 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W)) bus ();

  wave_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PHASE_W(PHASE_W),
                  .ROM_LAT(ROM_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural ROM: rom[a] = a[7:0], two cycles from address to data.
  logic [7:0] rom_q1, rom_q2;
  always @(posedge clk) begin
    rom_q1 <= bus.rom_addr[7:0];
    rom_q2 <= rom_q1;
  end
  assign bus.rom_q = rom_q2;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid = 0, n_wrap = 0, n_done = 0;
  int cyc = 0;

  // Playback model: a run is described by its start cycle, tuning word and
  // index of its last RUN cycle; everything else follows arithmetically.
  bit     m_active = 1'b0;
  longint m_s = 0, m_L = 0, m_tw = 1;

  function automatic longint addr_of(longint k, longint tw);
    return ((k * tw) % 65536) >> 6;
  endfunction

  function automatic bit carry_at(longint j, longint tw);
    return (((j + 1) * tw) >> 16) != ((j * tw) >> 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model update at each active edge from the inputs seen during that cycle.
  always @(posedge clk) begin
    longint k;
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      k = cyc - m_s;
      if (k == m_L + 3) m_active = 1'b0;
      else if (k <= m_L && bus.stop) m_L = k;
    end else if (bus.start && bus.tuning_word != 0) begin
      m_active = 1'b1;
      m_s  = cyc + 1;
      m_tw = bus.tuning_word;
      if (bus.num_periods != 0)
        m_L = (longint'(bus.num_periods) * 65536 + m_tw - 1) / m_tw - 1;
      else
        m_L = INF;
    end
    cyc++;
  end

  // Compare every cycle, mid-cycle, against the model.
  always @(negedge clk) begin
    longint k;
    logic [31:0] e_addr, e_sample;
    logic e_busy, e_done, e_wrap, e_valid, e_pdm;
    if (cyc > 0) begin
      if (m_active) begin
        k       = cyc - m_s;
        e_busy  = 1'b1;
        e_pdm   = 1'b0;
        e_done  = (k == m_L + 3);
        e_addr  = (k <= m_L) ? 32'(addr_of(k, m_tw)) : 32'd0;
        e_wrap  = (k >= 1 && k <= m_L + 1) ? carry_at(k - 1, m_tw) : 1'b0;
        e_valid = (k >= 3 && k <= m_L + 3);
        e_sample = (k < 3) ? 32'd128 : 32'(addr_of(k - 3, m_tw) & 255);
      end else begin
        e_busy = 1'b0; e_pdm = 1'b1; e_done = 1'b0; e_addr = 0;
        e_wrap = 1'b0; e_valid = 1'b0; e_sample = 128;
      end
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("pdm_rst", 32'(bus.pdm_rst), 32'(e_pdm));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("rom_addr", 32'(bus.rom_addr), e_addr);
      chk("period_wrap", 32'(bus.period_wrap), 32'(e_wrap));
      chk("sample_valid", 32'(bus.sample_valid), 32'(e_valid));
      chk("sample", 32'(bus.sample), e_sample);
      if (bus.sample_valid === 1'b1) n_valid++;
      if (bus.period_wrap === 1'b1) n_wrap++;
      if (bus.done === 1'b1) begin
        n_done++;
        $display("run done at cycle %0d (tw=%0d, valids so far %0d)", cyc, m_tw, n_valid);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_valid = 0; n_wrap = 0; n_done = 0;
  endtask

  task automatic pulse_start(input logic [15:0] tw, input logic [15:0] np);
    bus.tuning_word = tw;
    bus.num_periods = np;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!m_active && bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_idle_timeout", 32'(!ok), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.tuning_word = '0;
    bus.num_periods = '0;
    repeat (3) tick();
    chk("reset_sample", 32'(bus.sample), 32'd128);
    chk("reset_pdm_rst", 32'(bus.pdm_rst), 32'd1);
    rst = 1'b0;
    tick();

    // 1: one full period, step 1
    clr_counts();
    pulse_start(16'd64, 16'd1);
    chk("t1_first_addr", 32'(bus.rom_addr), 32'd0);
    repeat (5) tick();
    chk("t1_addr5", 32'(bus.rom_addr), 32'd5);
    wait_idle(2000);
    chk("t1_valids", n_valid, 1024);
    chk("t1_wraps", n_wrap, 1);
    chk("t1_dones", n_done, 1);
    $display("test1 tw=64 np=1: valids %0d wraps %0d", n_valid, n_wrap);

    // 2: three periods, step 2
    clr_counts();
    pulse_start(16'd128, 16'd3);
    tick();
    chk("t2_addr1", 32'(bus.rom_addr), 32'd2);
    wait_idle(2000);
    chk("t2_valids", n_valid, 1536);
    chk("t2_wraps", n_wrap, 3);
    chk("t2_dones", n_done, 1);
    $display("test2 tw=128 np=3: valids %0d wraps %0d", n_valid, n_wrap);

    // 3: continuous, stop after 300 RUN cycles, start pulses ignored
    clr_counts();
    pulse_start(16'd1000, 16'd0);
    repeat (100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (198) tick();
    bus.stop = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t3_busy_low_after_stop", n + 1, 4);
    chk("t3_valids", n_valid, 300);
    chk("t3_dones", n_done, 1);
    $display("test3 stop: valids %0d busy low %0d cycles after stop", n_valid, n + 1);

    // 4: zero tuning word ignored; mid-run changes have no effect
    clr_counts();
    pulse_start(16'd0, 16'd5);
    chk("t4_tw0_busy", 32'(bus.busy), 32'd0);
    chk("t4_tw0_pdm_rst", 32'(bus.pdm_rst), 32'd1);
    pulse_start(16'd2048, 16'd2);
    repeat (10) tick();
    bus.tuning_word = 16'd5000;
    bus.num_periods = 16'd9;
    tick();
    chk("t4_addr11", 32'(bus.rom_addr), 32'd352);
    wait_idle(500);
    chk("t4_valids", n_valid, 64);
    $display("test4 tw=2048 np=2 with changes: valids %0d", n_valid);

    // 5: reset mid-run, then replay from address 0
    clr_counts();
    pulse_start(16'd1024, 16'd0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_valid", 32'(bus.sample_valid), 32'd0);
    chk("t5_sample", 32'(bus.sample), 32'd128);
    chk("t5_pdm_rst", 32'(bus.pdm_rst), 32'd1);
    repeat (4) tick();
    chk("t5_no_done", n_done, 0);
    clr_counts();
    pulse_start(16'd1024, 16'd1);
    chk("t5_replay_addr0", 32'(bus.rom_addr), 32'd0);
    tick();
    chk("t5_replay_addr1", 32'(bus.rom_addr), 32'd16);
    wait_idle(500);
    chk("t5_valids", n_valid, 64);
    $display("test5 reset and replay: valids %0d", n_valid);

    // 6: half-range step, four periods
    clr_counts();
    pulse_start(16'h8000, 16'd4);
    chk("t6_addr0", 32'(bus.rom_addr), 32'd0);
    tick();
    chk("t6_addr1", 32'(bus.rom_addr), 32'd512);
    tick();
    chk("t6_addr2", 32'(bus.rom_addr), 32'd0);
    tick();
    chk("t6_addr3", 32'(bus.rom_addr), 32'd512);
    wait_idle(100);
    chk("t6_valids", n_valid, 8);
    chk("t6_wraps", n_wrap, 4);
    chk("t6_dones", n_done, 1);
    $display("test6 tw=0x8000 np=4: valids %0d wraps %0d", n_valid, n_wrap);

    // Randomized control traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom % 8 == 0);
      bus.stop  = ($urandom % 30 == 0);
      rst       = ($urandom % 250 == 0);
      bus.tuning_word = ($urandom % 6 == 0) ? 16'd0 : 16'($urandom_range(1024, 20000));
      bus.num_periods = 16'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b1;
    wait_idle(100);
    bus.stop = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
